scramb_code_gen: RTL and testbench

- Parametrised downlink Gold-code scrambling generator: a successor to the fixed 18-bit I/Q descrambler.
- Built from two 18-bit LFSRs: x with polynomial 1+X^7+X^18, y with polynomial 1+X^5+X^7+X^10+X^18.
- Adds run-time code-number selection (x pre-advance), a parametrised frame length with automatic reseed at frame wrap, an enable/valid handshake, frame-start marking and start/stop control.
- Sits between the cell-search/config controller and the chip-rate descrambler/despreader.

---
 rtl/scramb_code_gen.sv | 152 +++++++++++++++
 tb/tb_scramb_code_gen.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/scramb_code_gen.sv
// Downlink Gold-code scrambling generator: x (1+X^7+X^18) and y (1+X^5+X^7+X^10+X^18) LFSRs,
// code-number pre-advance of x, frame reseed and en/valid handshake. Optional SCRAMB_SYMBOL_MAP_EN adds +/-1 symbols.
module scramb_code_gen #(
  parameter int unsigned FRAME_LEN = 38400,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned CODE_W    = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [CODE_W-1:0] code_n,
  input  logic              en,
  output logic              chip_i,
  output logic              chip_q,
  output logic              chip_valid,
  output logic              frame_start,
  output logic              busy
`ifdef SCRAMB_SYMBOL_MAP_EN
  ,
  output logic [1:0]        sym_i,
  output logic [1:0]        sym_q
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADV  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  localparam logic [CNT_W-1:0]  LAST_CHIP = CNT_W'(FRAME_LEN - 1);
  localparam logic [17:0]       X_INIT    = 18'h00001;
  localparam logic [CODE_W-1:0] ADV_LAST  = CODE_W'(1);

  logic [1:0]        r_state;
  logic [17:0]       r_x;
  logic [17:0]       r_y;
  logic [17:0]       r_x_seed;
  logic [CNT_W-1:0]  r_chip_cnt;
  logic [CODE_W-1:0] r_adv_cnt;
  logic              r_chip_i;
  logic              r_chip_q;
  logic              r_chip_valid;
  logic              r_frame_start;
  logic              r_busy;

  logic [17:0] w_x_step;
  logic [17:0] w_y_step;
  logic        w_chip_i;
  logic        w_chip_q;

  assign w_x_step = {r_x[0] ^ r_x[7], r_x[17:1]};
  assign w_y_step = {r_y[0] ^ r_y[5] ^ r_y[7] ^ r_y[10], r_y[17:1]};

  // Chips come from the register contents before this cycle's step.
  assign w_chip_i = r_x[0] ^ r_y[0];
  assign w_chip_q = (r_x[4] ^ r_x[6] ^ r_x[15]) ^
                    (r_y[5] ^ r_y[6] ^ r_y[8] ^ r_y[9] ^ r_y[10] ^
                     r_y[11] ^ r_y[12] ^ r_y[13] ^ r_y[14] ^ r_y[15]);

`ifdef SCRAMB_SYMBOL_MAP_EN
  logic [1:0] r_sym_i;
  logic [1:0] r_sym_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_x           <= X_INIT;
      r_y           <= '1;
      r_x_seed      <= X_INIT;
      r_chip_cnt    <= '0;
      r_adv_cnt     <= '0;
      r_chip_i      <= 1'b0;
      r_chip_q      <= 1'b0;
      r_chip_valid  <= 1'b0;
      r_frame_start <= 1'b0;
      r_busy        <= 1'b0;
`ifdef SCRAMB_SYMBOL_MAP_EN
      r_sym_i       <= '0;
      r_sym_q       <= '0;
`endif
    end else begin
      r_chip_valid  <= 1'b0;
      r_frame_start <= 1'b0;
`ifdef SCRAMB_SYMBOL_MAP_EN
      r_sym_i       <= '0;
      r_sym_q       <= '0;
`endif
      if (start) begin
        r_x        <= X_INIT;
        r_y        <= '1;
        r_chip_cnt <= '0;
        r_adv_cnt  <= code_n;
        r_busy     <= 1'b1;
        if (code_n != '0) begin
          r_state <= S_ADV;
        end else begin
          r_state  <= S_RUN;
          r_x_seed <= X_INIT;
        end
      end else if (stop) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_ADV: begin
            r_x       <= w_x_step;
            r_adv_cnt <= r_adv_cnt - 1'b1;
            if (r_adv_cnt == ADV_LAST) begin
              r_x_seed <= w_x_step;
              r_state  <= S_RUN;
            end
          end
          S_RUN: begin
            if (en) begin
              r_chip_i      <= w_chip_i;
              r_chip_q      <= w_chip_q;
              r_chip_valid  <= 1'b1;
              r_frame_start <= (r_chip_cnt == '0);
`ifdef SCRAMB_SYMBOL_MAP_EN
              r_sym_i       <= w_chip_i ? 2'b11 : 2'b01;
              r_sym_q       <= w_chip_q ? 2'b11 : 2'b01;
`endif
              // Last chip of the frame: reseed instead of stepping so chip 0 repeats.
              if (r_chip_cnt == LAST_CHIP) begin
                r_x        <= r_x_seed;
                r_y        <= '1;
                r_chip_cnt <= '0;
              end else begin
                r_x        <= w_x_step;
                r_y        <= w_y_step;
                r_chip_cnt <= r_chip_cnt + 1'b1;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign chip_i      = r_chip_i;
  assign chip_q      = r_chip_q;
  assign chip_valid  = r_chip_valid;
  assign frame_start = r_frame_start;
  assign busy        = r_busy;
`ifdef SCRAMB_SYMBOL_MAP_EN
  assign sym_i       = r_sym_i;
  assign sym_q       = r_sym_q;
`endif

endmodule

// File: tb/tb_scramb_code_gen.sv
// Directed bench for scramb_code_gen with FRAME_LEN=10; expected chips come from
// sequence-recurrence models of the x and y m-sequences.
module tb_scramb_code_gen;

  localparam int FL = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        en = 1'b0;
  logic [12:0] code_n = '0;
  logic        chip_i, chip_q, chip_valid, frame_start, busy;
`ifdef SCRAMB_SYMBOL_MAP_EN
  logic [1:0]  sym_i, sym_q;
`endif

  int vec = 0;
  int errs = 0;
  logic xs [300];
  logic ys [300];
  logic last_i, last_q;

  always #5 clk = ~clk;

  scramb_code_gen #(.FRAME_LEN(FL), .CNT_W(4), .CODE_W(13)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .code_n(code_n), .en(en),
    .chip_i(chip_i), .chip_q(chip_q), .chip_valid(chip_valid),
    .frame_start(frame_start), .busy(busy)
`ifdef SCRAMB_SYMBOL_MAP_EN
    , .sym_i(sym_i), .sym_q(sym_q)
`endif
  );

  // Register bit k at time t equals sequence element t+k.
  function automatic logic m_i(int c, int n);
    int m = n % FL;
    return xs[c+m] ^ ys[m];
  endfunction

  function automatic logic m_q(int c, int n);
    int m = n % FL;
    return xs[c+m+4] ^ xs[c+m+6] ^ xs[c+m+15] ^
           ys[m+5] ^ ys[m+6] ^ ys[m+8] ^ ys[m+9] ^ ys[m+10] ^
           ys[m+11] ^ ys[m+12] ^ ys[m+13] ^ ys[m+14] ^ ys[m+15];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

`ifdef SCRAMB_SYMBOL_MAP_EN
  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask
`endif

  task automatic chk_chip(input string tag, input int c, input int n);
    logic ei, eq;
    ei = m_i(c, n);
    eq = m_q(c, n);
    chk1($sformatf("%s[%0d].valid", tag, n), chip_valid, 1'b1);
    chk1($sformatf("%s[%0d].i", tag, n), chip_i, ei);
    chk1($sformatf("%s[%0d].q", tag, n), chip_q, eq);
    chk1($sformatf("%s[%0d].fs", tag, n), frame_start, (n % FL) == 0);
    chk1($sformatf("%s[%0d].busy", tag, n), busy, 1'b1);
`ifdef SCRAMB_SYMBOL_MAP_EN
    chk2($sformatf("%s[%0d].sym_i", tag, n), sym_i, ei ? 2'b11 : 2'b01);
    chk2($sformatf("%s[%0d].sym_q", tag, n), sym_q, eq ? 2'b11 : 2'b01);
`endif
    last_i = ei;
    last_q = eq;
  endtask

  task automatic chk_quiet(input string tag, input logic exp_busy);
    chk1({tag, ".valid"}, chip_valid, 1'b0);
    chk1({tag, ".fs"}, frame_start, 1'b0);
    chk1({tag, ".busy"}, busy, exp_busy);
`ifdef SCRAMB_SYMBOL_MAP_EN
    chk2({tag, ".sym_i"}, sym_i, 2'b00);
    chk2({tag, ".sym_q"}, sym_q, 2'b00);
`endif
  endtask

  task automatic do_start(input int c);
    start = 1'b1;
    code_n = 13'(c);
    step();
    start = 1'b0;
  endtask

  initial begin
    logic pat [8];
    int n;

    for (int i = 0; i < 18; i++) begin
      xs[i] = (i == 0);
      ys[i] = 1'b1;
    end
    for (int i = 18; i < 300; i++) begin
      xs[i] = xs[i-18] ^ xs[i-11];
      ys[i] = ys[i-18] ^ ys[i-13] ^ ys[i-11] ^ ys[i-8];
    end

    // Reset state
    reset = 1'b1;
    step();
    step();
    chk_quiet("rst", 1'b0);
    chk1("rst.i", chip_i, 1'b0);
    chk1("rst.q", chip_q, 1'b0);
    reset = 1'b0;
    step();

    // code 0, en high: hand values I/Q = 0/0 then 1/0
    en = 1'b1;
    do_start(0);
    chk_quiet("c0.start", 1'b1);
    step();
    chk1("c0.hand0.i", chip_i, 1'b0);
    chk1("c0.hand0.q", chip_q, 1'b0);
    chk_chip("c0", 0, 0);
    step();
    chk1("c0.hand1.i", chip_i, 1'b1);
    chk1("c0.hand1.q", chip_q, 1'b0);
    chk_chip("c0", 0, 1);
    for (int k = 2; k < 5; k++) begin
      step();
      chk_chip("c0", 0, k);
    end

    // code 1: one ADVANCE cycle, first chip I=1, Q=0
    do_start(1);
    chk_quiet("c1.start", 1'b1);
    step();
    chk_quiet("c1.adv", 1'b1);
    step();
    chk1("c1.hand0.i", chip_i, 1'b1);
    chk1("c1.hand0.q", chip_q, 1'b0);
    chk_chip("c1", 1, 0);
    for (int k = 1; k < 4; k++) begin
      step();
      chk_chip("c1", 1, k);
    end

    // code 5: five ADVANCE cycles, then 25 chips across two frame wraps
    do_start(5);
    chk_quiet("c5.start", 1'b1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk_quiet($sformatf("c5.adv%0d", k), 1'b1);
    end
    for (int k = 0; k < 25; k++) begin
      step();
      chk_chip("c5", 5, k);
    end

    // code 2 with en toggling: no skipped or repeated chips
    en = 1'b0;
    do_start(2);
    step();
    step();
    chk_quiet("c2.adv", 1'b1);
    pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    n = 0;
    for (int k = 0; k < 8; k++) begin
      en = pat[k];
      step();
      if (pat[k]) begin
        chk_chip("c2", 2, n);
        n++;
      end else begin
        chk_quiet($sformatf("c2.gap%0d", k), 1'b1);
        chk1($sformatf("c2.hold%0d.i", k), chip_i, last_i);
        chk1($sformatf("c2.hold%0d.q", k), chip_q, last_q);
      end
    end

    // stop wins over en; then restart with code 3
    stop = 1'b1;
    en = 1'b1;
    step();
    stop = 1'b0;
    chk_quiet("stop", 1'b0);
    chk1("stop.hold.i", chip_i, last_i);
    chk1("stop.hold.q", chip_q, last_q);
    step();
    chk_quiet("idle.en", 1'b0);
    do_start(3);
    for (int k = 0; k < 3; k++) begin
      step();
      chk_quiet($sformatf("c3.adv%0d", k), 1'b1);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      chk_chip("c3", 3, k);
    end

    // Reset asserted mid-ADVANCE of code 100
    do_start(100);
    for (int k = 0; k < 40; k++) step();
    chk_quiet("c100.adv", 1'b1);
    reset = 1'b1;
    #2;
    chk_quiet("midrst", 1'b0);
    chk1("midrst.i", chip_i, 1'b0);
    chk1("midrst.q", chip_q, 1'b0);
    step();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      en = (k != 1);
      step();
      chk_quiet($sformatf("postrst%0d", k), 1'b0);
    end

    // Fresh start after reset reproduces code-0 chip 0
    en = 1'b1;
    do_start(0);
    step();
    chk_chip("c0b", 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
